// File: rtl/pipe_stage_register.sv
// -----------------------------------------------------------------------------
// pipe_stage_register
//
// Pipeline stage register with valid/ready flow control. It holds up to two
// entries: a main register that drives the outputs and an optional skid
// register. Each entry is a control field plus a payload.
//
// The control field carries the state-changing bits (register/memory write
// enables and similar). It is forced to zero whenever no entry is held, so a
// killed or absent entry can never commit anything downstream.
//
// Handshake: an entry transfers on a rising CLK edge when valid and ready are
// both high on that side (acc = In_Valid & In_Ready, deq = Out_Valid &
// Out_Ready). Once Out_Valid is high, Out_Ctrl and Out_Data stay bit-stable
// until deq. A sender never withdraws an entry based on ready.
//
// Parameters
//   DATA_W  payload width
//   CTRL_W  control-bit width (cleared on reset and flush)
//   SKID    1: two-entry skid buffer, registered In_Ready
//           0: single entry, In_Ready = !Out_Valid | Out_Ready
//
// Ports
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   FLUSH      synchronous kill of all held entries and of the incoming entry
//   In_Valid   upstream entry present
//   In_Ready   entry accepted this cycle
//   In_Ctrl    incoming control bits
//   In_Data    incoming payload
//   Out_Valid  downstream entry valid
//   Out_Ready  downstream consumes this cycle
//   Out_Ctrl   held control bits, zero when Out_Valid is 0
//   Out_Data   held payload
//   Occupancy  number of held entries (also the FSM state, for debug)
// -----------------------------------------------------------------------------
module pipe_stage_register #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FLUSH,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    // Encoding equals the number of held entries, so Occupancy is the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;

    logic                w_acc;
    logic                w_deq;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid_in;

    assign w_acc     = In_Valid & In_Ready;
    assign w_deq     = Out_Valid & Out_Ready;
    assign Out_Valid = (r_state != ST_EMPTY);
    assign Out_Ctrl  = r_main_ctrl;
    assign Out_Data  = r_main_data;
    assign Occupancy = r_state;

    // Next-state and load selects. FLUSH overrides every transition; with
    // FLUSH high no load is selected, so an entry accepted in that cycle is
    // dropped.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        if (FLUSH) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_next   = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_deq) begin
                        w_load_main_in = 1'b1;
                    end else if (w_acc && (SKID != 0)) begin
                        // Downstream stalled while a new entry arrived:
                        // park it in the skid register.
                        w_state_next   = ST_TWO;
                        w_load_skid_in = 1'b1;
                    end else if (w_deq) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_deq) begin
                        w_state_next     = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= In_Ctrl;
                r_main_data <= In_Data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end else if (w_state_next == ST_EMPTY) begin
                // Keeps Out_Ctrl zero whenever nothing is held; the payload
                // is left as-is since it is don't-care while invalid.
                r_main_ctrl <= '0;
            end

            if (w_load_skid_in) begin
                r_skid_ctrl <= In_Ctrl;
                r_skid_data <= In_Data;
            end else if (FLUSH) begin
                r_skid_ctrl <= '0;
            end
        end
    end

    // In_Ready is held low through reset and rises at the first edge after
    // release in both modes.
    if (SKID != 0) begin : g_skid
        logic r_in_ready;

        // Registered: depends on the next state only, so there is no
        // combinational path from Out_Ready to In_Ready.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_in_ready <= 1'b0;
            end else begin
                r_in_ready <= (w_state_next != ST_TWO);
            end
        end

        assign In_Ready = r_in_ready;
    end else begin : g_single
        logic r_live;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_live <= 1'b0;
            end else begin
                r_live <= 1'b1;
            end
        end

        assign In_Ready = r_live & (~Out_Valid | Out_Ready);
    end

endmodule
